// File: rtl/memory_stage.sv
// memory_stage: pipeline memory stage with a 256x8 data memory and writeback register.
//
// Ports:
//   clk            - single clock, rising edge
//   reset          - asynchronous active-low reset; clears outputs, FSM and all memory words
//   ans_ex         - execute result: memory address on memory ops, writeback value otherwise
//   B_Bypass       - store data
//   mem_en_ex      - 1 = memory access this cycle
//   mem_rw_ex      - 1 = store, 0 = load (meaningful only with mem_en_ex)
//   mem_mux_sel_ex - 1 = a load writes back the memory data, 0 = writes back ans_ex
//   RW_ex          - destination register (0 = no writeback)
//   flag_ex        - execute flags {P,V,Z,C}
//   ans_mem        - registered writeback value
//   RW_mem         - registered destination register
//   flag_mem       - registered flags
//   stall_mem      - combinational; 1 = upstream must hold all inputs stable
//
// Configuration:
//   MEM_WAIT_EN - when defined, every memory access takes WAIT_CYCLES (0-7) extra
//                 cycles via an IDLE/BUSY FSM; when undefined, stall_mem is tied 0
//                 and every access commits on the next edge.
module memory_stage #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] ans_ex,
    input  logic [7:0] B_Bypass,
    input  logic       mem_en_ex,
    input  logic       mem_rw_ex,
    input  logic       mem_mux_sel_ex,
    input  logic [4:0] RW_ex,
    input  logic [3:0] flag_ex,
    output logic [7:0] ans_mem,
    output logic [4:0] RW_mem,
    output logic [3:0] flag_mem,
    output logic       stall_mem
);

    logic [7:0] mem_q [256];
    logic [7:0] ans_q, ans_d;
    logic [4:0] rw_q, rw_d;
    logic [3:0] flag_q, flag_d;
    logic [7:0] rd_data;
    logic       stall;
    logic       commit;

`ifdef MEM_WAIT_EN
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic [0:0] state_q, state_d;
    logic [2:0] cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall   = 1'b0;
        if (state_q == IDLE) begin
            if (mem_en_ex && WAIT_CYCLES > 0) begin
                stall   = 1'b1;
                state_d = BUSY;
                cnt_d   = 3'(WAIT_CYCLES - 1);
            end
        end else if (cnt_q != 3'd0) begin
            stall = 1'b1;
            cnt_d = cnt_q - 3'd1;
        end else begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end
`else
    assign stall = 1'b0;
`endif

    assign commit  = !stall;
    assign rd_data = mem_q[ans_ex];

    // A stalled cycle registers a bubble: no destination, value and flags held.
    always_comb begin
        ans_d  = ans_q;
        rw_d   = 5'd0;
        flag_d = flag_q;
        if (commit) begin
            ans_d  = (mem_en_ex && !mem_rw_ex && mem_mux_sel_ex) ? rd_data : ans_ex;
            rw_d   = RW_ex;
            flag_d = flag_ex;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ans_q  <= 8'd0;
            rw_q   <= 5'd0;
            flag_q <= 4'd0;
            for (int i = 0; i < 256; i++) mem_q[i] <= 8'd0;
        end else begin
            ans_q  <= ans_d;
            rw_q   <= rw_d;
            flag_q <= flag_d;
            if (commit && mem_en_ex && mem_rw_ex) mem_q[ans_ex] <= B_Bypass;
        end
    end

    assign ans_mem   = ans_q;
    assign RW_mem    = rw_q;
    assign flag_mem  = flag_q;
    // Gated by reset so the stall output reads 0 while reset is held.
    assign stall_mem = stall & reset;

endmodule

// File: doc/memory_stage.md
MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 Parameter WAIT_CYCLES, default 2: wait states per memory access (range 0-7); used only when MEM_WAIT_EN is defined.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 ans_ex  input  8  execute-stage ALU result; memory address on memory ops, writeback value otherwise.
REQ-005 B_Bypass  input  8  store data.
REQ-006 mem_en_ex  input  1  1 = memory access this cycle.
REQ-007 mem_rw_ex  input  1  1 = write (store), 0 = read (load); valid only when mem_en_ex=1.
REQ-008 mem_mux_sel_ex  input  1  1 = writeback takes memory read data, 0 = takes ans_ex.
REQ-009 RW_ex  input  5  destination register; 0 = no writeback.
REQ-010 flag_ex  input  4  execute-stage flags {P,V,Z,C}.
REQ-011 ans_mem  output  8  registered writeback value.
REQ-012 RW_mem  output  5  registered destination register.
REQ-013 flag_mem  output  4  registered flags.
REQ-014 stall_mem  output  1  combinational; 1 = upstream SHALL hold all inputs stable.

Function
REQ-015 Internal data memory SHALL be 256 x 8, addressed by ans_ex[7:0].
REQ-016 Non-memory op (mem_en_ex=0): at the next edge, ans_mem<=ans_ex, RW_mem<=RW_ex, flag_mem<=flag_ex; latency 1; never stalls.
REQ-017 Store (mem_en_ex=1, mem_rw_ex=1): at the commit edge, mem[ans_ex]<=B_Bypass, ans_mem<=ans_ex, RW_mem<=RW_ex, flag_mem<=flag_ex.
REQ-018 Load (mem_en_ex=1, mem_rw_ex=0): at the commit edge, ans_mem<=(mem_mux_sel_ex ? mem[ans_ex] : ans_ex), RW_mem<=RW_ex, flag_mem<=flag_ex.
REQ-019 mem_mux_sel_ex=1 with mem_en_ex=0 SHALL select ans_ex; a store SHALL always set ans_mem to ans_ex.
REQ-020 Back-to-back store then load to the same address SHALL return the stored value.
REQ-021 Commit edge: the next edge without MEM_WAIT_EN; see REQ-023 to REQ-027 with it.

Configuration
REQ-022 Macro MEM_WAIT_EN. If undefined: no FSM, stall_mem tied 0, every access commits in 1 cycle.
REQ-023 If defined: FSM with two states, IDLE and BUSY, and a 3-bit wait counter cnt.
REQ-024 IDLE: if mem_en_ex=1 and WAIT_CYCLES>0, then stall_mem=1, go to BUSY, and cnt<=WAIT_CYCLES-1; otherwise behave as REQ-016 to REQ-018.
REQ-025 BUSY, cnt!=0: stall_mem=1, cnt decrements. BUSY, cnt==0: stall_mem=0, commit per REQ-017/018 at this cycle's edge, return to IDLE.
REQ-026 Access presented in cycle N SHALL commit at the end of cycle N+WAIT_CYCLES, with stall_mem=1 in cycles N..N+WAIT_CYCLES-1.
REQ-027 Every stalled cycle SHALL register a bubble: RW_mem<=0, ans_mem and flag_mem hold.
REQ-028 WAIT_CYCLES=0 with the macro defined SHALL behave identically to the macro undefined.

Reset
REQ-029 reset=0 SHALL immediately clear ans_mem, RW_mem, flag_mem, stall_mem, cnt and all memory words to 0, and set state to IDLE.
REQ-030 Reset during BUSY SHALL abort the access; no memory write occurs.
REQ-031 Operation SHALL resume on the first rising edge after reset rises.

Verification
REQ-032 Non-memory op, macro undefined: ans_ex=8'h3C, RW_ex=5, mem_en_ex=0 -> next cycle ans_mem=8'h3C, RW_mem=5, stall_mem=0.
REQ-033 Store then load, macro undefined: store B_Bypass=8'hA5 to address 8'h10, then load from 8'h10 with mem_mux_sel_ex=1, RW_ex=7 -> ans_mem=8'hA5, RW_mem=7 one cycle after the load.
REQ-034 Load with mem_mux_sel_ex=0: address 8'h10 holds 8'hA5 -> ans_mem=8'h10.
REQ-035 MEM_WAIT_EN, WAIT_CYCLES=2: load presented at cycle N -> stall_mem=1 in cycles N and N+1, RW_mem=0 after cycles N and N+1, data valid after cycle N+2.
REQ-036 MEM_WAIT_EN: assert reset during BUSY of a store of 8'hFF to 8'h20 -> afterwards a load of 8'h20 returns 8'h00, and state is IDLE.
REQ-037 Reset while idle: with all outputs nonzero, drive reset=0 between edges -> all outputs 0 before the next edge.
